// File: rtl/dual_issue_dispatch_if.sv
// Fetch/hazard-side inputs and issue-side outputs of the dual-issue dispatch stage.
// The master modport drives fetch and hazard signals. The slave modport is the dispatch stage itself.
interface dual_issue_dispatch_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32
);
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic                   fetch_v2;
  logic [INSTR_WIDTH-1:0] instr1;
  logic [INSTR_WIDTH-1:0] instr2;
  logic [PC_WIDTH-1:0]    pc1;
  logic [PC_WIDTH-1:0]    pc2;
  logic                   type1;
  logic                   type2;
  logic [6:0]             rt1;
  logic [6:0]             rt2;
  logic                   wr1;
  logic                   wr2;
  logic                   stall;
  logic                   flush;
  logic                   even_valid;
  logic                   odd_valid;
  logic [INSTR_WIDTH-1:0] even_instr;
  logic [INSTR_WIDTH-1:0] odd_instr;
  logic [PC_WIDTH-1:0]    even_pc;
  logic [PC_WIDTH-1:0]    odd_pc;
  logic [CNT_WIDTH-1:0]   issue_count;
  logic [CNT_WIDTH-1:0]   dual_count;

  modport master (
    output fetch_valid, fetch_v2, instr1, instr2, pc1, pc2, type1, type2,
           rt1, rt2, wr1, wr2, stall, flush,
    input  fetch_ready, even_valid, odd_valid, even_instr, odd_instr,
           even_pc, odd_pc, issue_count, dual_count
  );

  modport slave (
    input  fetch_valid, fetch_v2, instr1, instr2, pc1, pc2, type1, type2,
           rt1, rt2, wr1, wr2, stall, flush,
    output fetch_ready, even_valid, odd_valid, even_instr, odd_instr,
           even_pc, odd_pc, issue_count, dual_count
  );
endinterface

// File: rtl/dual_issue_dispatch.sv
// Issue stage: buffers one fetched pair, serialises same-pipe or same-destination pairs,
// routes instructions to the even/odd pipes, and holds on stall or discards on flush.
module dual_issue_dispatch #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  dual_issue_dispatch_if.slave bus
);
  // state  | meaning:  EMPTY no slots buffered | PAIR slots A and B | SINGLE slot A only
  typedef enum logic [1:0] {EMPTY, PAIR, SINGLE} state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
    logic                   typ;
    logic [6:0]             rt;
    logic                   wr;
  } slot_t;

  state_t     state;
  slot_t      slot_a, slot_b, in1, in2;
  logic       conflict, accept;
  logic [1:0] issue_n;

  assign in1 = {bus.instr1, bus.pc1, bus.type1, bus.rt1, bus.wr1};
  assign in2 = {bus.instr2, bus.pc2, bus.type2, bus.rt2, bus.wr2};

  assign conflict = (state == PAIR) &&
                    ((slot_a.typ == slot_b.typ) ||
                     (slot_a.wr && slot_b.wr && (slot_a.rt == slot_b.rt)));

  assign bus.fetch_ready = !bus.flush && !bus.stall &&
                           ((state == EMPTY) || (state == SINGLE) ||
                            ((state == PAIR) && !conflict));
  assign accept = bus.fetch_valid && bus.fetch_ready;

  always_comb begin
    issue_n = 2'd0;
    if (!bus.flush && !bus.stall) begin
      if (state == PAIR)        issue_n = conflict ? 2'd1 : 2'd2;
      else if (state == SINGLE) issue_n = 2'd1;
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= EMPTY;
      slot_a          <= '0;
      slot_b          <= '0;
      bus.even_valid  <= 1'b0;
      bus.odd_valid   <= 1'b0;
      bus.even_instr  <= '0;
      bus.odd_instr   <= '0;
      bus.even_pc     <= '0;
      bus.odd_pc      <= '0;
      bus.issue_count <= '0;
      bus.dual_count  <= '0;
    end else begin
      bus.even_valid <= 1'b0;
      bus.odd_valid  <= 1'b0;
      if (bus.flush) begin
        state <= EMPTY;
      end else if (!bus.stall) begin
        // Slot A always goes first; B only goes alongside it when the pair is conflict-free.
        if (issue_n != 2'd0) begin
          if (slot_a.typ) begin
            bus.odd_valid <= 1'b1;
            bus.odd_instr <= slot_a.instr;
            bus.odd_pc    <= slot_a.pc;
          end else begin
            bus.even_valid <= 1'b1;
            bus.even_instr <= slot_a.instr;
            bus.even_pc    <= slot_a.pc;
          end
        end
        if (issue_n == 2'd2) begin
          if (slot_b.typ) begin
            bus.odd_valid <= 1'b1;
            bus.odd_instr <= slot_b.instr;
            bus.odd_pc    <= slot_b.pc;
          end else begin
            bus.even_valid <= 1'b1;
            bus.even_instr <= slot_b.instr;
            bus.even_pc    <= slot_b.pc;
          end
          bus.dual_count <= sat_add(bus.dual_count, 2'd1);
        end
        bus.issue_count <= sat_add(bus.issue_count, issue_n);

        if (accept) begin
          slot_a <= in1;
          slot_b <= in2;
          state  <= bus.fetch_v2 ? PAIR : SINGLE;
        end else if (conflict) begin
          slot_a <= slot_b;
          state  <= SINGLE;
        end else begin
          state  <= EMPTY;
        end
      end
    end
  end
endmodule
